// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_IMM,
        S_WR_REG
    } state_t;

    // IR layout, MSB first; the packed struct lines up bit-for-bit with the IR.
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } ir_fields_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op encodings under OPC_MOV
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    // op encodings under OPC_ALU
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [1:0] VSEL_MDATA = 2'b11;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_C     = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational IR decode: field split, immediate sign extension, legality.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output ir_fields_t  fields,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        illegal
);

    assign fields = ir_fields_t'(ir);
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // Every op under the ALU opcode is defined; only two ops exist under MOV.
    always_comb begin
        illegal = 1'b1;
        if (fields.opcode == OPC_ALU)
            illegal = 1'b0;
        else if (fields.opcode == OPC_MOV &&
                 (fields.op == OP_MOV_IMM || fields.op == OP_MOV_REG))
            illegal = 1'b0;
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and control FSM sequencing the datapath strobes.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        bad_op,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_t      state, state_nxt;
    logic [15:0] ir;
    ir_fields_t  f;
    logic        illegal;
    logic        is_mov, is_mov_imm, is_cmp, is_mvn;

    instr_decoder u_dec (
        .ir      (ir),
        .fields  (f),
        .sximm8  (sximm8),
        .sximm5  (sximm5),
        .illegal (illegal)
    );

    assign is_mov     = (f.opcode == OPC_MOV);
    assign is_mov_imm = is_mov && (f.op == OP_MOV_IMM);
    assign is_cmp     = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
    assign is_mvn     = (f.opcode == OPC_ALU) && (f.op == OP_MVN);

    // State register; IR only loads while idle so a running instruction is stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && load)
                ir <= in;
        end
    end

    // Next-state and Moore outputs from state plus IR.
    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        bad_op    = 1'b0;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        ALUop     = ALU_ADD;
        unique case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (illegal) begin
                    bad_op    = 1'b1;
                    state_nxt = S_WAIT;
                end else if (is_mov_imm)
                    state_nxt = S_WR_IMM;
                else if (is_mov || is_mvn)
                    state_nxt = S_GET_B;
                else
                    state_nxt = S_GET_A;
            end
            S_GET_A: begin
                readnum   = f.rn;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                readnum   = f.rm;
                loadb     = 1'b1;
                state_nxt = S_ALU;
            end
            S_ALU: begin
                shift = f.sh;
                // MOV reg and MVN have no A operand, so A is forced to zero.
                asel  = is_mov || is_mvn;
                ALUop = is_mov ? ALU_ADD : f.op;
                if (is_cmp) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WR_REG;
                end
            end
            S_WR_IMM: begin
                writenum  = f.rn;
                vsel      = VSEL_IMM8;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WR_REG: begin
                writenum  = f.rd;
                vsel      = VSEL_C;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule
